// File: rtl/shared_buf_arbiter.sv
// shared_buf_arbiter: N-way request/release arbiter for shared buffers.
// Fixed-priority (index 0 highest) or round-robin selection, chosen by RR_MODE.
// Every release passes through IDLE, so consumers always see a grant == 0 gap.
// Optional grant-hold watchdog is compiled in when ARB_TIMEOUT_EN is defined.
// Without it, timeout/timeout_id are tied low.

module shared_buf_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned RR_MODE        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned IDW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] rel,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_id,
  output logic             busy,
  output logic             timeout,
  output logic [IDW-1:0]   timeout_id
);

  // Parameter legality, checked at elaboration.
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("shared_buf_arbiter: N_REQ must be in 2..16");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 20)) begin : g_bad_timeout
    $error("shared_buf_arbiter: TIMEOUT_CYCLES must be in 2..2^20");
  end

  typedef enum logic {StIdle, StGranted} state_e;

  state_e           state_q;
  logic [N_REQ-1:0] grant_q;
  logic [IDW-1:0]   grant_id_q;
  logic [IDW-1:0]   last_q;
  logic             busy_q;

  logic             win_valid;
  logic [IDW-1:0]   win_id;
  logic             hi_found;
  logic [IDW-1:0]   hi_id;
  logic             holder_rel;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0]  hold_cnt_q;
  logic             timeout_q;
  logic [IDW-1:0]   timeout_id_q;
`endif

  // Winner select: lowest requester overall, or in round-robin mode the lowest
  // requester above the previous holder, wrapping to the lowest overall.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    hi_found  = 1'b0;
    hi_id     = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_valid = 1'b1;
        win_id    = IDW'(i);
        if (RR_MODE != 0 && i > int'(last_q)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
    if (hi_found) begin
      win_id = hi_id;
    end
  end

  // Only the holder's own release bit counts; grant_q is one-hot or zero.
  assign holder_rel = |(rel & grant_q);

  // Arbiter FSM with registered outputs and optional hold watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      last_q       <= IDW'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
`endif
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            state_q    <= StGranted;
            grant_q    <= N_REQ'(1) << win_id;
            grant_id_q <= win_id;
            busy_q     <= 1'b1;
            last_q     <= win_id;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
          end
        end
        StGranted: begin
          if (holder_rel) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_cnt_q == TermCnt) begin
            // Revoke; last_q already names this holder, so RR ranks it last.
            state_q      <= StIdle;
            grant_q      <= '0;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b1;
            timeout_id_q <= grant_id_q;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

`ifdef ARB_TIMEOUT_EN
  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;
`else
  assign timeout    = 1'b0;
  assign timeout_id = '0;
`endif

endmodule

// File: tb/tb_shared_buf_arbiter.sv
// Bench for shared_buf_arbiter: three instances (2-way fixed, 4-way fixed,
// 4-way round-robin) driven in lockstep. A reference model predicts each
// instance's outputs per cycle into a queue, popped and compared after the edge.
// Directed sequences add constant expectations on top of the model.

module tb_shared_buf_arbiter;

  localparam int unsigned ToCycles = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       to;
    logic [1:0] toid;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rst_drv;
  logic [1:0] req0, rel0;
  logic [3:0] req1, rel1, req2, rel2;

  logic [1:0] g0;
  logic [0:0] id0, tid0;
  logic       b0, to0;
  logic [3:0] g1, g2;
  logic [1:0] id1, tid1, id2, tid2;
  logic       b1, to1, b2, to2;

  int n_cmp = 0;
  int n_err = 0;

  obs_t exp_q[$];

  logic m_busy [3];
  int   m_id   [3];
  int   m_last [3];
  int   m_cnt  [3];
  logic m_to   [3];
  int   m_toid [3];

  always #5 clk = ~clk;

  shared_buf_arbiter #(.N_REQ(2), .RR_MODE(0), .TIMEOUT_CYCLES(ToCycles)) u_fp2 (
    .clk(clk), .reset_n(reset_n), .req(req0), .rel(rel0), .grant(g0), .grant_id(id0),
    .busy(b0), .timeout(to0), .timeout_id(tid0)
  );

  shared_buf_arbiter #(.N_REQ(4), .RR_MODE(0), .TIMEOUT_CYCLES(ToCycles)) u_fp4 (
    .clk(clk), .reset_n(reset_n), .req(req1), .rel(rel1), .grant(g1), .grant_id(id1),
    .busy(b1), .timeout(to1), .timeout_id(tid1)
  );

  shared_buf_arbiter #(.N_REQ(4), .RR_MODE(1), .TIMEOUT_CYCLES(ToCycles)) u_rr4 (
    .clk(clk), .reset_n(reset_n), .req(req2), .rel(rel2), .grant(g2), .grant_id(id2),
    .busy(b2), .timeout(to2), .timeout_id(tid2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int n_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic obs_t observe(input int k);
    obs_t o;
    o = '0;
    case (k)
      0: begin
        o.grant = {2'b00, g0}; o.id = {1'b0, id0}; o.busy = b0;
        o.to = to0; o.toid = {1'b0, tid0};
      end
      1: begin
        o.grant = g1; o.id = id1; o.busy = b1; o.to = to1; o.toid = tid1;
      end
      default: begin
        o.grant = g2; o.id = id2; o.busy = b2; o.to = to2; o.toid = tid2;
      end
    endcase
    return o;
  endfunction

  task automatic model_reset(input int k);
    m_busy[k] = 1'b0;
    m_id[k]   = 0;
    m_last[k] = n_of(k) - 1;
    m_cnt[k]  = 0;
    m_to[k]   = 1'b0;
    m_toid[k] = 0;
  endtask

  // Advance model k across one active edge, given inputs sampled at that edge.
  task automatic model_step(input int k, input logic [3:0] reqv, input logic [3:0] relv);
    int n;
    int w;
    n = n_of(k);
    if (!reset_n) begin
      model_reset(k);
      return;
    end
    m_to[k]   = 1'b0;
    m_toid[k] = 0;
    if (!m_busy[k]) begin
      w = -1;
      if (k == 2) begin
        for (int off = 1; off <= n; off++) begin
          if (w < 0 && reqv[(m_last[k] + off) % n]) w = (m_last[k] + off) % n;
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          if (w < 0 && reqv[i]) w = i;
        end
      end
      if (w >= 0) begin
        m_busy[k] = 1'b1;
        m_id[k]   = w;
        m_last[k] = w;
        m_cnt[k]  = 0;
      end
    end else if (relv[m_id[k]]) begin
      m_busy[k] = 1'b0;
      m_id[k]   = 0;
    end else if (ToEn && m_cnt[k] == int'(ToCycles) - 1) begin
      m_busy[k] = 1'b0;
      m_to[k]   = 1'b1;
      m_toid[k] = m_id[k];
      m_id[k]   = 0;
    end else begin
      m_cnt[k]++;
    end
  endtask

  function automatic obs_t model_out(input int k);
    obs_t o;
    o.grant = m_busy[k] ? (4'b0001 << m_id[k]) : 4'b0000;
    o.id    = 2'(m_id[k]);
    o.busy  = m_busy[k];
    o.to    = m_to[k];
    o.toid  = 2'(m_toid[k]);
    return o;
  endfunction

  // One clock cycle: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic step(input logic [1:0] q0, input logic [1:0] r0, input logic [3:0] q1,
                      input logic [3:0] r1, input logic [3:0] q2, input logic [3:0] r2);
    obs_t e, o;
    @(negedge clk);
    reset_n = rst_drv;
    req0 = q0; rel0 = r0; req1 = q1; rel1 = r1; req2 = q2; rel2 = r2;
    model_step(0, {2'b00, q0}, {2'b00, r0});
    exp_q.push_back(model_out(0));
    model_step(1, q1, r1);
    exp_q.push_back(model_out(1));
    model_step(2, q2, r2);
    exp_q.push_back(model_out(2));
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      o = observe(k);
      if (exp_q.size() == 0) begin
        check_val($sformatf("sb_empty%0d", k), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_val($sformatf("grant%0d", k), 32'(o.grant), 32'(e.grant));
        check_val($sformatf("grant_id%0d", k), 32'(o.id), 32'(e.id));
        check_val($sformatf("busy%0d", k), 32'(o.busy), 32'(e.busy));
        check_val($sformatf("timeout%0d", k), 32'(o.to), 32'(e.to));
        check_val($sformatf("timeout_id%0d", k), 32'(o.toid), 32'(e.toid));
      end
    end
  endtask

  task automatic step0(input logic [1:0] q, input logic [1:0] r);
    step(q, r, 4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic step1(input logic [3:0] q, input logic [3:0] r);
    step(2'b00, 2'b00, q, r, 4'h0, 4'h0);
  endtask

  initial begin
    int hi_cnt;
    int to_cnt;
    int to_id;
    int ids[$];
    logic [3:0] prev;
    int exp_rr[5];

    reset_n = 1'b1;
    rst_drv = 1'b0;
    req0 = '0; rel0 = '0; req1 = '0; rel1 = '0; req2 = '0; rel2 = '0;
    #1 reset_n = 1'b0;
    for (int k = 0; k < 3; k++) model_reset(k);

    // Reset state, with requests present that must be ignored.
    step(2'b11, 2'b00, 4'hf, 4'h0, 4'hf, 4'h0);
    check_val("rst_grant1", 32'(g1), 32'd0);
    check_val("rst_busy2", 32'(b2), 32'd0);
    step(2'b00, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0);
    rst_drv = 1'b1;
    step(2'b00, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0);

    // Basic grant on the 2-way instance.
    step0(2'b10, 2'b00);
    check_val("basic_grant", 32'(g0), 32'b10);
    check_val("basic_id", 32'(id0), 32'd1);
    for (int i = 0; i < 4; i++) step0(2'b10, 2'b00);
    step0(2'b00, 2'b10);
    check_val("basic_rel", 32'(g0), 32'd0);
    step0(2'b00, 2'b00);

    // Fixed-priority conflict and re-grant after one idle cycle.
    step1(4'b1010, 4'b0000);
    check_val("fp_grant", 32'(g1), 32'b0010);
    step1(4'b1010, 4'b0010);
    check_val("fp_gap", 32'(g1), 32'd0);
    step1(4'b1010, 4'b0000);
    check_val("fp_regrant", 32'(g1), 32'b0010);
    step1(4'b0000, 4'b0010);
    step1(4'b0000, 4'b0000);

    // Releases from non-holders are ignored.
    step1(4'b0100, 4'b0000);
    step1(4'b0100, 4'b1001);
    check_val("ign_grant", 32'(g1), 32'b0100);
    check_val("ign_busy", 32'(b1), 32'd1);
    step1(4'b0000, 4'b0100);
    check_val("ign_rel", 32'(g1), 32'd0);

    // Round-robin fairness: holder releases in its first granted cycle.
    prev = '0;
    for (int s = 0; s < 12; s++) begin
      step(2'b00, 2'b00, 4'h0, 4'h0, 4'b1111, g2);
      if (b2 && prev == 4'h0) ids.push_back(int'(id2));
      prev = g2;
    end
    exp_rr = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("rr_seq%0d", i), (i < ids.size()) ? 32'(ids[i]) : 32'hff,
                32'(exp_rr[i]));
    end
    step(2'b00, 2'b00, 4'h0, 4'h0, 4'h0, g2);

    // Watchdog: holder 1 never releases.
    hi_cnt = 0; to_cnt = 0; to_id = 0;
    for (int s = 0; s <= 8; s++) begin
      step0(2'b10, 2'b00);
      if (g0 != 2'b00) hi_cnt++;
      if (to0) begin
        to_cnt++;
        to_id = int'(tid0);
      end
    end
    check_val("wd_hold", 32'(hi_cnt), ToEn ? 32'd8 : 32'd9);
    check_val("wd_pulses", 32'(to_cnt), ToEn ? 32'd1 : 32'd0);
    check_val("wd_id", 32'(to_id), ToEn ? 32'd1 : 32'd0);
    step0(2'b10, 2'b00);
    check_val("wd_pulse_len", 32'(to0), 32'd0);
    step0(2'b00, 2'b10);
    step0(2'b00, 2'b00);

    // Watchdog: release on the terminal cycle is a normal release.
    for (int s = 0; s < 8; s++) step0(2'b10, 2'b00);
    step0(2'b10, 2'b10);
    check_val("wd_rel_to", 32'(to0), 32'd0);
    check_val("wd_rel_grant", 32'(g0), 32'd0);
    step0(2'b00, 2'b00);

    // Asynchronous reset mid-grant.
    step0(2'b01, 2'b00);
    check_val("ar_pre", 32'(g0), 32'b01);
    #3 reset_n = 1'b0;
    rst_drv = 1'b0;
    #1;
    check_val("ar_grant", 32'(g0), 32'd0);
    check_val("ar_busy", 32'(b0), 32'd0);
    check_val("ar_id", 32'(id0), 32'd0);
    check_val("ar_to", 32'(to0), 32'd0);
    for (int k = 0; k < 3; k++) model_reset(k);
    step0(2'b01, 2'b00);
    rst_drv = 1'b1;
    step0(2'b01, 2'b00);
    check_val("ar_first_grant", 32'(g0), 32'b01);
    step0(2'b00, 2'b01);

    // Random traffic on all instances against the model.
    for (int s = 0; s < 400; s++) begin
      step(2'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
           4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
           4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
